// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_pkg
//  Purpose  : Shared types and constants for the TDM receive demultiplexer.
//             Holds the receive FSM state enum, the default slot count and
//             the helper that derives the slot-counter width from N.
//  Revision : 1.0 - initial release
// ============================================================================
package tdm_pkg;

   // Receive FSM: IDLE waits for a frame marker, RECV collects slots 1..N-1.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RECV = 1'b1
   } tdm_state_e;

   localparam int DEFAULT_N = 2;

   // Slot counter width; never below one bit so the counter always exists.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_slot_counter
//  Purpose  : Slot position counter for the TDM receiver.
//  Ports    : clk   - system clock
//             reset - synchronous active-high reset (cnt -> 0)
//             clear - force cnt to 0 (frame completed)
//             load1 - force cnt to 1 (slot 0 just taken on a frame marker)
//             inc   - advance cnt by one
//             cnt   - current slot index
//             last  - cnt is the final slot (N-1)
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_slot_counter
   import tdm_pkg::*;
#(
   parameter  int N  = DEFAULT_N,
   localparam int CW = cnt_width(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          load1,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          last
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // clear beats load1 beats inc; the FSM never asserts more than one anyway.
   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load1) begin
         cnt_d = CW'(1);
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CW'(N - 1));

endmodule : tdm_slot_counter
`default_nettype wire

// File: rtl/tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tdm_demux
//  Purpose  : Receive end of a 1-bit time-multiplexed link. A frame marker
//             (sync) flags slot 0; each en strobe samples one slot into a
//             shadow register, and the completed frame is published on dout
//             with a one-cycle valid pulse. A marker arriving mid-frame drops
//             the partial frame, pulses err and restarts at slot 0.
//  Ports    : clk   - system clock
//             reset - synchronous active-high reset
//             en    - slot strobe (din/sync sampled only when high)
//             sync  - frame marker, current strobe is slot 0
//             din   - serial slot data
//             dout  - last complete frame, bit k = slot k
//             valid - one-cycle pulse, dout just updated
//             err   - one-cycle pulse, marker seen mid-frame
//             busy  - frame partly received (FSM in RECV)
//  Revision : 1.0 - initial release
// ============================================================================
module tdm_demux
   import tdm_pkg::*;
#(
   parameter  int N  = DEFAULT_N,
   localparam int CW = cnt_width(N)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         sync,
   input  logic         din,
   output logic [N-1:0] dout,
   output logic         valid,
   output logic         err,
   output logic         busy
);

   tdm_state_e    state_q,  state_d;
   logic [N-1:0]  shadow_q, shadow_d;
   logic [N-1:0]  dout_q,   dout_d;
   logic          valid_q,  valid_d;
   logic          err_q,    err_d;
   logic          busy_q,   busy_d;

   logic          cnt_clear;
   logic          cnt_load1;
   logic          cnt_inc;
   logic [CW-1:0] cnt;
   logic          cnt_last;

   tdm_slot_counter #(.N(N)) u_slot_counter (
      .clk   (clk),
      .reset (reset),
      .clear (cnt_clear),
      .load1 (cnt_load1),
      .inc   (cnt_inc),
      .cnt   (cnt),
      .last  (cnt_last)
   );

   always_comb begin
      state_d   = state_q;
      shadow_d  = shadow_q;
      dout_d    = dout_q;
      valid_d   = 1'b0;
      err_d     = 1'b0;
      cnt_clear = 1'b0;
      cnt_load1 = 1'b0;
      cnt_inc   = 1'b0;

      if (en) begin
         if (sync) begin
            // A marker always starts a fresh frame; inside RECV it also
            // abandons whatever was collected so far, last slot included.
            err_d       = (state_q == RECV);
            shadow_d    = '0;
            shadow_d[0] = din;
            cnt_load1   = 1'b1;
            state_d     = RECV;
         end else if (state_q == RECV) begin
            if (cnt_last) begin
               dout_d    = {din, shadow_q[N-2:0]};
               valid_d   = 1'b1;
               cnt_clear = 1'b1;
               state_d   = IDLE;
            end else begin
               shadow_d[cnt] = din;
               cnt_inc       = 1'b1;
            end
         end
         // IDLE without a marker: stray slot, ignored silently.
      end

      busy_d = (state_d == RECV);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         shadow_q <= '0;
         dout_q   <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shadow_q <= shadow_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign dout  = dout_q;
   assign valid = valid_q;
   assign err   = err_q;
   assign busy  = busy_q;

endmodule : tdm_demux
`default_nettype wire

// File: tb/tb_tdm_demux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tdm_demux
//  Purpose  : Self-checking bench for tdm_demux. Two instances (N=2, N=4)
//             share one stimulus stream; a frame-level reference model
//             predicts both every cycle, and directed tables add explicit
//             expected values for the N=2 and N=4 corner cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tdm_demux;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       sync;
   logic       din;
   logic [1:0] dout2;
   logic       valid2, err2, busy2;
   logic [3:0] dout4;
   logic       valid4, err4, busy4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tdm_demux #(.N(2)) dut2 (
      .clk(clk), .reset(reset), .en(en), .sync(sync), .din(din),
      .dout(dout2), .valid(valid2), .err(err2), .busy(busy2)
   );

   tdm_demux #(.N(4)) dut4 (
      .clk(clk), .reset(reset), .en(en), .sync(sync), .din(din),
      .dout(dout4), .valid(valid4), .err(err4), .busy(busy4)
   );

   // ---------------- reference model (index 0: N=2, index 1: N=4) ---------
   // A frame is a list of received bits; -1 bits collected means no frame.
   int         m_have [2];
   bit  [3:0]  m_bits [2];
   bit  [3:0]  m_dout [2];
   bit         m_valid[2];
   bit         m_err  [2];

   function automatic int slots(input int k);
      return (k == 0) ? 2 : 4;
   endfunction

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         m_valid[k] = 1'b0;
         m_err[k]   = 1'b0;
         if (reset) begin
            m_have[k] = -1;
            m_bits[k] = '0;
            m_dout[k] = '0;
         end else if (en) begin
            if (sync) begin
               if (m_have[k] >= 0) m_err[k] = 1'b1;
               m_bits[k] = {3'b000, din};
               m_have[k] = 1;
            end else if (m_have[k] >= 0) begin
               m_bits[k][m_have[k]] = din;
               m_have[k]++;
               if (m_have[k] == slots(k)) begin
                  m_dout[k]  = m_bits[k];
                  m_valid[k] = 1'b1;
                  m_have[k]  = -1;
               end
            end
         end
      end
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("n2.dout",  {2'b00, dout2},  m_dout[0]);
      chk("n2.valid", {3'b000, valid2}, {3'b000, m_valid[0]});
      chk("n2.err",   {3'b000, err2},   {3'b000, m_err[0]});
      chk("n2.busy",  {3'b000, busy2},  {3'b000, m_have[0] >= 0});
      chk("n4.dout",  dout4,            m_dout[1]);
      chk("n4.valid", {3'b000, valid4}, {3'b000, m_valid[1]});
      chk("n4.err",   {3'b000, err4},   {3'b000, m_err[1]});
      chk("n4.busy",  {3'b000, busy4},  {3'b000, m_have[1] >= 0});
   endtask

   // One clock: drive inputs, let the edge happen, check 1 time unit later.
   task automatic cycle(input logic r, input logic e, input logic s, input logic d);
      reset = r; en = e; sync = s; din = d;
      @(posedge clk);
      model_step();
      #1;
      model_check();
   endtask

   // ---------------- directed table (expected values for N=2) -------------
   typedef struct {
      logic       rst, en, sync, din;
      logic [1:0] dout;
      logic       valid, err, busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic e, input logic s, input logic d,
                      input logic [1:0] o, input logic v, input logic x, input logic b);
      vec_t t;
      t.rst = r; t.en = e; t.sync = s; t.din = d;
      t.dout = o; t.valid = v; t.err = x; t.busy = b;
      tbl.push_back(t);
   endtask

   // N=4 mid-frame sequence: {en,sync,din, exp dout, valid, err, busy}
   typedef struct {
      logic       en, sync, din;
      logic [3:0] dout;
      logic       valid, err, busy;
   } vec4_t;

   vec4_t seq4[$];

   task automatic add4(input logic e, input logic s, input logic d,
                       input logic [3:0] o, input logic v, input logic x, input logic b);
      vec4_t t;
      t.en = e; t.sync = s; t.din = d;
      t.dout = o; t.valid = v; t.err = x; t.busy = b;
      seq4.push_back(t);
   endtask

   initial begin
      int err4_count;

      for (int k = 0; k < 2; k++) begin
         m_have[k] = -1; m_bits[k] = '0; m_dout[k] = '0;
         m_valid[k] = 1'b0; m_err[k] = 1'b0;
      end
      reset = 1'b1; en = 1'b0; sync = 1'b0; din = 1'b0;

      //   rst en sy di  dout  v  e  b
      // reset during a partial frame, then a stray strobe is ignored
      add(1, 0, 0, 0, 2'b00, 0, 0, 0);
      add(0, 1, 1, 1, 2'b00, 0, 0, 1);
      add(1, 1, 0, 1, 2'b00, 0, 0, 0);
      add(1, 0, 0, 0, 2'b00, 0, 0, 0);
      add(0, 1, 0, 1, 2'b00, 0, 0, 0);
      // basic frames
      add(0, 1, 1, 1, 2'b00, 0, 0, 1);
      add(0, 1, 0, 0, 2'b01, 1, 0, 0);
      add(0, 0, 0, 0, 2'b01, 0, 0, 0);
      add(0, 1, 1, 0, 2'b01, 0, 0, 1);
      add(0, 1, 0, 1, 2'b10, 1, 0, 0);
      add(0, 0, 0, 0, 2'b10, 0, 0, 0);
      // gapped strobes
      add(0, 1, 1, 1, 2'b10, 0, 0, 1);
      add(0, 0, 0, 0, 2'b10, 0, 0, 1);
      add(0, 0, 1, 0, 2'b10, 0, 0, 1);
      add(0, 0, 0, 1, 2'b10, 0, 0, 1);
      add(0, 1, 0, 1, 2'b11, 1, 0, 0);
      add(0, 0, 0, 0, 2'b11, 0, 0, 0);
      // back-to-back 01, 10, 11
      add(0, 1, 1, 1, 2'b11, 0, 0, 1);
      add(0, 1, 0, 0, 2'b01, 1, 0, 0);
      add(0, 1, 1, 0, 2'b01, 0, 0, 1);
      add(0, 1, 0, 1, 2'b10, 1, 0, 0);
      add(0, 1, 1, 1, 2'b10, 0, 0, 1);
      add(0, 1, 0, 1, 2'b11, 1, 0, 0);
      // exhaustive (slot1, slot0)
      add(0, 1, 1, 0, 2'b11, 0, 0, 1);
      add(0, 1, 0, 0, 2'b00, 1, 0, 0);
      add(0, 1, 1, 1, 2'b00, 0, 0, 1);
      add(0, 1, 0, 0, 2'b01, 1, 0, 0);
      add(0, 1, 1, 0, 2'b01, 0, 0, 1);
      add(0, 1, 0, 1, 2'b10, 1, 0, 0);
      add(0, 1, 1, 1, 2'b10, 0, 0, 1);
      add(0, 1, 0, 1, 2'b11, 1, 0, 0);
      // marker on the last slot restarts instead of completing
      add(0, 1, 1, 0, 2'b11, 0, 0, 1);
      add(0, 1, 1, 1, 2'b11, 0, 1, 1);
      add(0, 1, 0, 0, 2'b01, 1, 0, 0);
      add(0, 0, 0, 0, 2'b01, 0, 0, 0);

      //    en sy di  dout    v  e  b
      add4(1, 1, 1, 4'b0000, 0, 0, 1);
      add4(1, 0, 0, 4'b0000, 0, 0, 1);
      add4(1, 0, 1, 4'b0000, 0, 0, 1);
      add4(1, 1, 0, 4'b0000, 0, 1, 1);
      add4(1, 0, 1, 4'b0000, 0, 0, 1);
      add4(1, 0, 1, 4'b0000, 0, 0, 1);
      add4(1, 0, 0, 4'b0110, 1, 0, 0);
      add4(0, 0, 0, 4'b0110, 0, 0, 0);

      @(negedge clk);

      foreach (tbl[i]) begin
         cycle(tbl[i].rst, tbl[i].en, tbl[i].sync, tbl[i].din);
         chk($sformatf("tbl[%0d].dout", i),  {2'b00, dout2},  {2'b00, tbl[i].dout});
         chk($sformatf("tbl[%0d].valid", i), {3'b000, valid2}, {3'b000, tbl[i].valid});
         chk($sformatf("tbl[%0d].err", i),   {3'b000, err2},   {3'b000, tbl[i].err});
         chk($sformatf("tbl[%0d].busy", i),  {3'b000, busy2},  {3'b000, tbl[i].busy});
      end

      // N=4 mid-frame marker: partial frame 1,0,1 must never surface
      cycle(1, 0, 0, 0);
      err4_count = 0;
      foreach (seq4[i]) begin
         cycle(1'b0, seq4[i].en, seq4[i].sync, seq4[i].din);
         if (err4 === 1'b1) err4_count++;
         chk($sformatf("seq4[%0d].dout", i),  dout4,            seq4[i].dout);
         chk($sformatf("seq4[%0d].valid", i), {3'b000, valid4}, {3'b000, seq4[i].valid});
         chk($sformatf("seq4[%0d].err", i),   {3'b000, err4},   {3'b000, seq4[i].err});
         chk($sformatf("seq4[%0d].busy", i),  {3'b000, busy4},  {3'b000, seq4[i].busy});
      end
      chk("seq4.err_pulses", 4'(err4_count), 4'd1);

      // randomized traffic, model-checked on both instances
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 199) == 0),
               ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < 2),
               1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_tdm_demux
`default_nettype wire
